// File: rtl/lc3_control_fsm.sv
// lc3_control_fsm -- LC-3 instruction sequencer/decoder (Moore FSM).
//
// Runs fetch (S18/S33/S35), decode (S32) and execute for ADD/AND/NOT/BR/JMP/
// JSR/JSRR/LDR/STR/PAUSE. All datapath loads, bus gates, mux selects and SRAM
// strobes are decoded from the current state and the wait counter only.
// Opcodes outside that set go back to fetch with no side effect.
//
// Parameters:
//   MEM_RD_WAIT  cycles Mem_OE is held low per read (>=1). LD_MDR pulses on the last one.
//   MEM_WR_WAIT  cycles Mem_WE is held low per write (>=1).
//
// Optional feature:
//   LC3_SINGLE_STEP_EN  When defined, the FSM holds after each fetch in PAUSE_IR1
//                       until ContinueIR=1, then in PAUSE_IR2 until ContinueIR=0.
//
// Ports:
//   Clk, Reset_n             clock (rising edge) and async active-low reset
//   Run, Continue, ContinueIR start from HALTED, PAUSE resume, single-step resume
//   Opcode, IR_5, IR_11, BEN instruction fields and branch enable
//   LD_*                     register load enables
//   Gate*                    bus drivers; at most one is high in any state
//   PCMUX..ALUK              datapath mux selects and ALU function
//   Mem_CE/UB/LB/OE/WE       SRAM strobes, active low. CE/UB/LB are tied low.
//   State_dbg                encoded current state, for the hex display
module lc3_control_fsm #(
  parameter int MEM_RD_WAIT = 2,
  parameter int MEM_WR_WAIT = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Run,
  input  logic       Continue,
  input  logic       ContinueIR,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic [1:0] DRMUX,
  output logic [1:0] SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic       MARMUX,
  output logic [1:0] ALUK,
  output logic       Mem_CE,
  output logic       Mem_UB,
  output logic       Mem_LB,
  output logic       Mem_OE,
  output logic       Mem_WE,
  output logic [4:0] State_dbg
);

  localparam int MAX_WAIT = (MEM_RD_WAIT > MEM_WR_WAIT) ? MEM_RD_WAIT : MEM_WR_WAIT;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(MEM_RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(MEM_WR_WAIT - 1);

  // State codes double as the State_dbg display value.
  // LC-3 state numbers are kept where they fit in 5 bits.
  localparam logic [4:0] ST_S00     = 5'd0;
  localparam logic [4:0] ST_S01     = 5'd1;
  localparam logic [4:0] ST_S04     = 5'd4;
  localparam logic [4:0] ST_S05     = 5'd5;
  localparam logic [4:0] ST_S06     = 5'd6;
  localparam logic [4:0] ST_S07     = 5'd7;
  localparam logic [4:0] ST_S09     = 5'd9;
  localparam logic [4:0] ST_S32     = 5'd10;
  localparam logic [4:0] ST_S33     = 5'd11;
  localparam logic [4:0] ST_S12     = 5'd12;
  localparam logic [4:0] ST_S35     = 5'd13;
  localparam logic [4:0] ST_PAUSE_1 = 5'd14;
  localparam logic [4:0] ST_PAUSE_2 = 5'd15;
  localparam logic [4:0] ST_S16     = 5'd16;
  localparam logic [4:0] ST_S18     = 5'd18;
  localparam logic [4:0] ST_S20     = 5'd20;
  localparam logic [4:0] ST_S21     = 5'd21;
  localparam logic [4:0] ST_S22     = 5'd22;
  localparam logic [4:0] ST_S23     = 5'd23;
  localparam logic [4:0] ST_S25     = 5'd25;
  localparam logic [4:0] ST_S27     = 5'd27;
  localparam logic [4:0] ST_HALTED  = 5'd31;
`ifdef LC3_SINGLE_STEP_EN
  localparam logic [4:0] ST_PAUSE_IR1 = 5'd2;
  localparam logic [4:0] ST_PAUSE_IR2 = 5'd3;
`endif

  logic [4:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ir5_q, ir5_d;
  logic             wait_state;

`ifndef LC3_SINGLE_STEP_EN
  logic unused_continue_ir;
  assign unused_continue_ir = ContinueIR;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HALTED:  if (Run) state_d = ST_S18;
      ST_S18:     state_d = ST_S33;
      ST_S33:     if (cnt_q == RD_LAST) state_d = ST_S35;
`ifdef LC3_SINGLE_STEP_EN
      ST_S35:       state_d = ST_PAUSE_IR1;
      ST_PAUSE_IR1: if (ContinueIR) state_d = ST_PAUSE_IR2;
      ST_PAUSE_IR2: if (!ContinueIR) state_d = ST_S32;
`else
      ST_S35:     state_d = ST_S32;
`endif
      ST_S32: begin
        case (Opcode)
          4'b0001: state_d = ST_S01;
          4'b0101: state_d = ST_S05;
          4'b1001: state_d = ST_S09;
          4'b0000: state_d = ST_S00;
          4'b1100: state_d = ST_S12;
          4'b0100: state_d = ST_S04;
          4'b0110: state_d = ST_S06;
          4'b0111: state_d = ST_S07;
          4'b1101: state_d = ST_PAUSE_1;
          default: state_d = ST_S18;
        endcase
      end
      ST_S01, ST_S05, ST_S09: state_d = ST_S18;
      ST_S00:     state_d = BEN ? ST_S22 : ST_S18;
      ST_S22:     state_d = ST_S18;
      ST_S12:     state_d = ST_S18;
      ST_S04:     state_d = IR_11 ? ST_S21 : ST_S20;
      ST_S20:     state_d = ST_S18;
      ST_S21:     state_d = ST_S18;
      ST_S06:     state_d = ST_S25;
      ST_S07:     state_d = ST_S23;
      ST_S25:     if (cnt_q == RD_LAST) state_d = ST_S27;
      ST_S27:     state_d = ST_S18;
      ST_S23:     state_d = ST_S16;
      ST_S16:     if (cnt_q == WR_LAST) state_d = ST_S18;
      ST_PAUSE_1: if (Continue) state_d = ST_PAUSE_2;
      ST_PAUSE_2: if (!Continue) state_d = ST_S18;
      default:    state_d = ST_HALTED;
    endcase

    wait_state = (state_q == ST_S33) || (state_q == ST_S25) || (state_q == ST_S16);
    cnt_d = (wait_state && (state_d == state_q)) ? cnt_q + CNT_W'(1) : '0;

    // IR is stable from S35 until the next fetch. Capturing IR[5] at decode
    // keeps SR2MUX a pure function of registered state.
    ir5_d = (state_q == ST_S32) ? IR_5 : ir5_q;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_HALTED;
      cnt_q   <= '0;
      ir5_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ir5_q   <= ir5_d;
    end
  end

  assign Mem_CE    = 1'b0;
  assign Mem_UB    = 1'b0;
  assign Mem_LB    = 1'b0;
  assign State_dbg = state_q;

  always_comb begin
    LD_MAR = 1'b0; LD_MDR = 1'b0; LD_IR = 1'b0; LD_BEN = 1'b0;
    LD_CC = 1'b0; LD_REG = 1'b0; LD_PC = 1'b0;
    GatePC = 1'b0; GateMDR = 1'b0; GateALU = 1'b0; GateMARMUX = 1'b0;
    PCMUX = '0; DRMUX = '0; SR1MUX = '0; SR2MUX = 1'b0;
    ADDR1MUX = 1'b0; ADDR2MUX = '0; MARMUX = 1'b0; ALUK = '0;
    Mem_OE = 1'b1; Mem_WE = 1'b1;
    case (state_q)
      ST_S18: begin
        GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1;
      end
      ST_S33, ST_S25: begin
        Mem_OE = 1'b0;
        LD_MDR = (cnt_q == RD_LAST);
      end
      ST_S35: begin
        GateMDR = 1'b1; LD_IR = 1'b1;
      end
      ST_S32: LD_BEN = 1'b1;
      ST_S01, ST_S05, ST_S09: begin
        SR1MUX = 2'b01; SR2MUX = ir5_q;
        GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
        ALUK = (state_q == ST_S01) ? 2'b00 : (state_q == ST_S05) ? 2'b01 : 2'b10;
      end
      ST_S22: begin
        ADDR2MUX = 2'b10; PCMUX = 2'b10; LD_PC = 1'b1;
      end
      ST_S12, ST_S20: begin
        SR1MUX = 2'b01; ADDR1MUX = 1'b1; PCMUX = 2'b10; LD_PC = 1'b1;
      end
      ST_S04: begin
        DRMUX = 2'b01; GatePC = 1'b1; LD_REG = 1'b1;
      end
      ST_S21: begin
        ADDR2MUX = 2'b11; PCMUX = 2'b10; LD_PC = 1'b1;
      end
      ST_S06, ST_S07: begin
        SR1MUX = 2'b01; ADDR1MUX = 1'b1; ADDR2MUX = 2'b01;
        GateMARMUX = 1'b1; LD_MAR = 1'b1;
      end
      ST_S27: begin
        GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
      end
      ST_S23: begin
        ALUK = 2'b11; GateALU = 1'b1; LD_MDR = 1'b1;
      end
      ST_S16: Mem_WE = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Testbench for lc3_control_fsm.
// It runs directed and random instructions against an instruction-level
// reference model of the expected control word for each cycle.
module tb_lc3_control_fsm;

  localparam int RD_WAIT = 3;
  localparam int WR_WAIT = 2;

  logic       Clk = 1'b0;
  logic       Reset_n, Run, Continue, ContinueIR;
  logic [3:0] Opcode;
  logic       IR_5, IR_11, BEN;
  logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC;
  logic       GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX, DRMUX, SR1MUX, ADDR2MUX, ALUK;
  logic       SR2MUX, ADDR1MUX, MARMUX;
  logic       Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;
  logic [4:0] State_dbg;

  lc3_control_fsm #(.MEM_RD_WAIT(RD_WAIT), .MEM_WR_WAIT(WR_WAIT)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .Continue(Continue), .ContinueIR(ContinueIR),
    .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN), .LD_CC(LD_CC),
    .LD_REG(LD_REG), .LD_PC(LD_PC), .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU),
    .GateMARMUX(GateMARMUX), .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
    .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .MARMUX(MARMUX), .ALUK(ALUK),
    .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
    .State_dbg(State_dbg)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc;
    logic gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux, drmux, sr1mux;
    logic sr2mux, addr1mux;
    logic [1:0] addr2mux;
    logic marmux;
    logic [1:0] aluk;
    logic mem_ce, mem_ub, mem_lb, mem_oe, mem_we;
    logic [4:0] dbg;
  } cw_t;

  cw_t got;
  assign got = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC,
                GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DRMUX, SR1MUX,
                SR2MUX, ADDR1MUX, ADDR2MUX, MARMUX, ALUK,
                Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, State_dbg};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // Expected control word for a named step of an instruction.
  // "L" variants are the last cycle of a read, where MDR loads.
  function automatic cw_t word_of(input string s, input logic ir5);
    cw_t w;
    w = '0;
    w.mem_oe = 1'b1;
    w.mem_we = 1'b1;
    case (s)
      "HALT": w.dbg = 5'd31;
      "S18":  begin w.gate_pc = 1; w.ld_mar = 1; w.ld_pc = 1; w.dbg = 5'd18; end
      "S33":  begin w.mem_oe = 0; w.dbg = 5'd11; end
      "S33L": begin w.mem_oe = 0; w.ld_mdr = 1; w.dbg = 5'd11; end
      "S35":  begin w.gate_mdr = 1; w.ld_ir = 1; w.dbg = 5'd13; end
      "S32":  begin w.ld_ben = 1; w.dbg = 5'd10; end
      "S01", "S05", "S09": begin
        w.sr1mux = 2'b01; w.sr2mux = ir5; w.gate_alu = 1; w.ld_reg = 1; w.ld_cc = 1;
        w.aluk = (s == "S01") ? 2'b00 : (s == "S05") ? 2'b01 : 2'b10;
        w.dbg  = (s == "S01") ? 5'd1 : (s == "S05") ? 5'd5 : 5'd9;
      end
      "S00":  w.dbg = 5'd0;
      "S22":  begin w.addr2mux = 2'b10; w.pcmux = 2'b10; w.ld_pc = 1; w.dbg = 5'd22; end
      "S12", "S20": begin
        w.sr1mux = 2'b01; w.addr1mux = 1; w.pcmux = 2'b10; w.ld_pc = 1;
        w.dbg = (s == "S12") ? 5'd12 : 5'd20;
      end
      "S04":  begin w.drmux = 2'b01; w.gate_pc = 1; w.ld_reg = 1; w.dbg = 5'd4; end
      "S21":  begin w.addr2mux = 2'b11; w.pcmux = 2'b10; w.ld_pc = 1; w.dbg = 5'd21; end
      "S06", "S07": begin
        w.sr1mux = 2'b01; w.addr1mux = 1; w.addr2mux = 2'b01; w.gate_marmux = 1; w.ld_mar = 1;
        w.dbg = (s == "S06") ? 5'd6 : 5'd7;
      end
      "S25":  begin w.mem_oe = 0; w.dbg = 5'd25; end
      "S25L": begin w.mem_oe = 0; w.ld_mdr = 1; w.dbg = 5'd25; end
      "S27":  begin w.gate_mdr = 1; w.ld_reg = 1; w.ld_cc = 1; w.dbg = 5'd27; end
      "S23":  begin w.aluk = 2'b11; w.gate_alu = 1; w.ld_mdr = 1; w.dbg = 5'd23; end
      "S16":  begin w.mem_we = 0; w.dbg = 5'd16; end
      "P1":   w.dbg = 5'd14;
      "P2":   w.dbg = 5'd15;
      "PIR1": w.dbg = 5'd2;
      "PIR2": w.dbg = 5'd3;
      default: w.dbg = 5'bxxxxx;
    endcase
    return w;
  endfunction

  // One instruction: step names, plus the Continue/ContinueIR values
  // driven before the clock edge that ends each step.
  string q_name[$];
  logic  q_cont[$];
  logic  q_cir[$];

  task automatic push(input string s, input logic c, input logic ci);
    q_name.push_back(s);
    q_cont.push_back(c);
    q_cir.push_back(ci);
  endtask

  task automatic push_pause(input string a, input string b, input int hold, input int press,
                            input bit is_ir);
    for (int i = 0; i <= hold; i++) begin
      if (is_ir) push(a, 1'($urandom), (i == hold));
      else       push(a, (i == hold), 1'($urandom));
    end
    for (int i = 1; i <= press; i++) begin
      if (is_ir) push(b, 1'($urandom), (i != press));
      else       push(b, (i != press), 1'($urandom));
    end
  endtask

  task automatic build(input logic [3:0] op, input logic ben, input logic ir11, input int ir_hold);
    q_name.delete(); q_cont.delete(); q_cir.delete();
    push("S18", 1'($urandom), 1'($urandom));
    for (int i = 1; i <= RD_WAIT; i++) push((i == RD_WAIT) ? "S33L" : "S33", 1'($urandom), 1'($urandom));
    push("S35", 1'($urandom), 1'($urandom));
`ifdef LC3_SINGLE_STEP_EN
    push_pause("PIR1", "PIR2", ir_hold, 1 + int'($urandom_range(0, 3)), 1'b1);
`endif
    push("S32", 1'($urandom), 1'($urandom));
    case (op)
      4'b0001: push("S01", 1'($urandom), 1'($urandom));
      4'b0101: push("S05", 1'($urandom), 1'($urandom));
      4'b1001: push("S09", 1'($urandom), 1'($urandom));
      4'b0000: begin
        push("S00", 1'($urandom), 1'($urandom));
        if (ben) push("S22", 1'($urandom), 1'($urandom));
      end
      4'b1100: push("S12", 1'($urandom), 1'($urandom));
      4'b0100: begin
        push("S04", 1'($urandom), 1'($urandom));
        push(ir11 ? "S21" : "S20", 1'($urandom), 1'($urandom));
      end
      4'b0110: begin
        push("S06", 1'($urandom), 1'($urandom));
        for (int i = 1; i <= RD_WAIT; i++) push((i == RD_WAIT) ? "S25L" : "S25", 1'($urandom), 1'($urandom));
        push("S27", 1'($urandom), 1'($urandom));
      end
      4'b0111: begin
        push("S07", 1'($urandom), 1'($urandom));
        push("S23", 1'($urandom), 1'($urandom));
        for (int i = 0; i < WR_WAIT; i++) push("S16", 1'($urandom), 1'($urandom));
      end
      4'b1101: push_pause("P1", "P2", int'($urandom_range(0, 4)), 1 + int'($urandom_range(0, 3)), 1'b0);
      default: ;
    endcase
  endtask

  // Called just after a falling edge: check steps [0, upto) one per cycle.
  task automatic play(input int upto, input int idx);
    for (int i = 0; i < upto; i++) begin
      check($sformatf("i%0d op%b %s", idx, Opcode, q_name[i]), 64'(got), 64'(word_of(q_name[i], IR_5)));
      if (!Mem_OE && !Mem_WE) check($sformatf("i%0d oe_we_overlap", idx), 64'(1), 64'(0));
      Continue   = q_cont[i];
      ContinueIR = q_cir[i];
      Run        = 1'($urandom);
      @(negedge Clk);
    end
  endtask

  logic [3:0] dir_op[12]   = '{4'b0001, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0111,
                              4'b1111, 4'b0110, 4'b1101, 4'b0101, 4'b1001, 4'b1100};
  logic       dir_ben[12]  = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  logic       dir_ir11[12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
  logic       dir_ir5[12]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1};

  initial begin
    Reset_n = 1'b0; Run = 1'b0; Continue = 1'b0; ContinueIR = 1'b0;
    Opcode = '0; IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0;
    @(negedge Clk);
    check("reset_word", 64'(got), 64'(word_of("HALT", 1'b0)));
    Run = 1'b1;
    @(negedge Clk);
    check("run_during_reset", 64'(got), 64'(word_of("HALT", 1'b0)));
    Reset_n = 1'b1; Run = 1'b0;
    repeat (3) begin
      @(negedge Clk);
      check("halted_idle", 64'(got), 64'(word_of("HALT", 1'b0)));
    end
    Run = 1'b1;
    @(negedge Clk);

    for (int n = 0; n < 60; n++) begin
      if (n < 12) begin
        Opcode = dir_op[n]; BEN = dir_ben[n]; IR_11 = dir_ir11[n]; IR_5 = dir_ir5[n];
      end else begin
        Opcode = 4'($urandom); BEN = 1'($urandom); IR_11 = 1'($urandom); IR_5 = 1'($urandom);
      end
      build(Opcode, BEN, IR_11, (n == 0) ? 100 : int'($urandom_range(0, 4)));
      play(q_name.size(), n);
    end

    // Reset in the first write cycle of a store. The strobes must release at once.
    Opcode = 4'b0111; IR_5 = 1'b0; BEN = 1'b0; IR_11 = 1'b0;
    build(Opcode, 1'b0, 1'b0, 2);
    begin
      int k;
      k = 0;
      while (q_name[k] != "S16") k++;
      play(k, 99);
    end
    check("s16_before_reset", 64'(got), 64'(word_of("S16", 1'b0)));
    #2 Reset_n = 1'b0; Run = 1'b1;
    #1 check("async_reset_mid_s16", 64'(got), 64'(word_of("HALT", 1'b0)));
    repeat (2) begin
      @(negedge Clk);
      check("run_ignored_in_reset", 64'(got), 64'(word_of("HALT", 1'b0)));
    end
    Reset_n = 1'b1; Run = 1'b0;
    @(negedge Clk);
    check("halted_after_reset", 64'(got), 64'(word_of("HALT", 1'b0)));
    Run = 1'b1;
    @(negedge Clk);
    check("restart_s18", 64'(got), 64'(word_of("S18", 1'b0)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
